// File: rtl/cim_pkg.sv
// cim_pkg: shared widths, lane counts, saturation bounds and shift clamp for the CIM output quantizer
package cim_pkg;
  localparam int ACC_W = 51;
  localparam int LANES8 = 8;
  localparam int LANES16 = 4;
  localparam int SAT8_MAX = 127;
  localparam int SAT8_MIN = -128;
  localparam int SAT16_MAX = 32767;
  localparam int SAT16_MIN = -32768;
  localparam int SH_MAX = 50;
  function automatic logic [5:0] clamp_shift(input logic [5:0] s);
    return (s > 6'(SH_MAX)) ? 6'(SH_MAX) : s;
  endfunction
endpackage

// File: rtl/cim_word_fifo.sv
// cim_word_fifo: small synchronous FIFO; head is zero while empty so outputs read 0 after reset
module cim_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/cim_out_quant.sv
// cim_out_quant: requantizes CIM accumulator sums (round-half-up shift, saturate) and packs them into a FIFO of 64-bit words
module cim_out_quant
  import cim_pkg::*;
#(
  parameter int ACC_W = cim_pkg::ACC_W,
  parameter int WORD_W = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ACC_W-1:0]  nout,
  input  logic              st,
  input  logic [5:0]        cfg_shift,
  input  logic              cfg_obit,
  input  logic              flush,
  input  logic              clr_flags,
  output logic [WORD_W-1:0] m_data,
  output logic [3:0]        m_lanes,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              sat_flag,
  output logic              ovf_flag,
  output logic              busy
);
  logic [5:0] sh_q;
  logic obit_q, armed, v1, v2, pend;
  logic signed [ACC_W:0] acc1, r2, rnd, sum, hi, lo;
  logic [15:0] q;
  logic sat_ev, full_w, flush_go, push, pop, f_full, f_empty;
  logic [3:0] lane_cnt, lanes_n, base_cnt;
  logic [6:0] sh_amt;
  logic [WORD_W-1:0] asm_w, base_w, lane_val;
  assign rnd = (sh_q == '0) ? '0 : (ACC_W+1)'(1) << (sh_q - 6'd1);
  assign sum = acc1 + rnd;
  assign hi = obit_q ? (ACC_W+1)'(SAT16_MAX) : (ACC_W+1)'(SAT8_MAX);
  assign lo = obit_q ? (ACC_W+1)'(SAT16_MIN) : (ACC_W+1)'(SAT8_MIN);
  assign q = (r2 > hi) ? hi[15:0] : (r2 < lo) ? lo[15:0] : r2[15:0];
  assign sat_ev = v2 && (r2 > hi || r2 < lo);
  assign lane_val = obit_q ? WORD_W'(q) : WORD_W'(q[7:0]);
  assign lanes_n = obit_q ? 4'(LANES16) : 4'(LANES8);
  // A completed word sits one cycle before it is pushed; a new lane can land in the fresh word meanwhile.
  assign full_w = lane_cnt >= lanes_n;
  assign flush_go = pend && !v1 && !v2 && !full_w;
  assign push = full_w || (flush_go && lane_cnt != '0);
  assign base_w = full_w ? '0 : asm_w;
  assign base_cnt = full_w ? '0 : lane_cnt;
  assign sh_amt = obit_q ? {base_cnt[2:0], 4'b0} : {1'b0, base_cnt[2:0], 3'b0};
  assign pop = m_valid && m_ready;
  assign m_valid = !f_empty;
  assign busy = v1 || v2 || lane_cnt != '0 || pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      obit_q <= 1'b0;
      armed <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      acc1 <= '0;
      r2 <= '0;
      lane_cnt <= '0;
      asm_w <= '0;
      pend <= 1'b0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (!en) begin
        sh_q <= clamp_shift(cfg_shift);
        obit_q <= cfg_obit;
      end
      armed <= en && (armed || !st);
      v1 <= en && armed && st;
      acc1 <= {nout[ACC_W-1], nout};
      v2 <= v1;
      r2 <= sum >>> sh_q;
      asm_w <= v2 ? (base_w | (lane_val << sh_amt)) : push ? '0 : asm_w;
      lane_cnt <= v2 ? base_cnt + 4'd1 : push ? '0 : lane_cnt;
      pend <= flush || (pend && !flush_go);
      sat_flag <= (sat_flag && !clr_flags) || sat_ev;
      ovf_flag <= (ovf_flag && !clr_flags) || (push && f_full && !pop);
    end
  end
  cim_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W + 4)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({lane_cnt, asm_w}),
    .dout({m_lanes, m_data}),
    .full(f_full),
    .empty(f_empty)
  );
endmodule

// File: doc/cim_out_quant.md
Name: cim_out_quant

Overview:
Downstream consumer of the CIM macro's global accumulator output (nout, 51-bit signed, completed when st pulses).
- Captures each completed dot-product sum and requantizes it: arithmetic right shift with round-half-up, then saturation to signed 8 or 16 bits.
- Packs results into 64-bit words and buffers them in a small FIFO with a valid/ready master interface towards the output bus / next layer.

Parameters:
ACC_W, 51, accumulator width of nout
WORD_W, 64, packed output word width (fixed lane math assumes 64)
FIFO_DEPTH, 4, output word FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  block enable; capture only while high
nout  in  ACC_W  signed accumulator sum from global IO
st  in  1  window-complete strobe from gctrl; nout final when st=1
cfg_shift  in  6  right-shift amount, 0..50
cfg_obit  in  1  0 = 8-bit lanes (8/word), 1 = 16-bit lanes (4/word)
flush  in  1  single-cycle request to emit the partial word
clr_flags  in  1  clear sticky flags
m_data  out  WORD_W  FIFO head word, lane 0 at LSB
m_lanes  out  4  valid lanes in m_data (1..8)
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head when m_valid&&m_ready
sat_flag  out  1  sticky: any result saturated
ovf_flag  out  1  sticky: a word was dropped because the FIFO was full
busy  out  1  pipeline or packer holds data

Behaviour:
- Reset: all outputs 0; armed=0; lane count=0; FIFO empty; pending flush cleared. Reset mid-operation discards everything in flight.
- Config shadowing: cfg_shift/cfg_obit copied into shadow regs every cycle with en=0. Ignored while en=1; changes mid-run have no effect. cfg_shift >50 clamps to 50.
- Arming: armed<=0 when en=0; armed<=1 on any cycle with en=1 and st=0. This discards the st=1 held during/after reset and any window started before enable.
- Capture (S1): on a cycle with en&&armed&&st, register nout sign-extended to 52 bits; v1<=1. Otherwise v1<=0.
- Round/shift (S2, next cycle): r = (acc + (sh? 1<<(sh-1) : 0)) >>> sh, signed 52-bit; v2<=v1.
- Saturate/pack (S3, next cycle):
  - Clamp r to [-128,127] or [-32768,32767]; set sat_flag if clamped.
  - Write into lane[lane_cnt] of the assembly word; lane_cnt++.
  - When lane_cnt reaches 8 (8-bit) or 4 (16-bit): push word with m_lanes=full count, clear assembly word to 0, lane_cnt<=0.
- Latency: st-capture edge T; S2 at T+1; S3 lane write at T+2; a completing word is written to the FIFO at edge T+3; m_valid high from the following cycle if the FIFO was empty.
- Flush:
  - Flush sets pending_flush.
  - When v1=v2=0 and no S3 write is occurring, a pending flush with lane_cnt>0 pushes the zero-padded partial word with m_lanes=lane_cnt, then clears pending_flush.
  - A pending flush with lane_cnt=0 simply clears.
  - Flush on the same cycle as a word completion: the full word is pushed first, and the flush then finds lane_cnt=0.
- FIFO:
  - Registered head output.
  - Push while full with no pop: word dropped, ovf_flag set.
  - Push and pop in the same cycle while full: both occur.
  - Pop only when m_valid&&m_ready.
  - m_data/m_lanes stable while m_valid&&!m_ready.
- Sticky flags: cleared by rst or clr_flags. A set event on the same cycle as clr_flags wins (flag stays 1).
- busy = v1|v2|(lane_cnt!=0)|pending_flush.
- Back-to-back st: gctrl spacing is ≥12 cycles, but the pipeline must still accept st on consecutive cycles (fully pipelined, no stall). FIFO backpressure never stalls capture; it only drops words.

Decomposition:
- Package cim_pkg: ACC_W; lane counts LANES8=8, LANES16=4; SAT8/SAT16 min/max constants; shift clamp value 50.
- One sub-module: cim_word_fifo (parameterized depth/width sync FIFO, push/pop/full/empty, carries {m_lanes,m_data}).
- Round/saturate stays inline.

Test Plan:
- 8-bit mode, shift 0, st windows with nout=1..8 → one word 0x0807060504030201, m_lanes=8, m_valid 3 cycles after the 8th capture edge.
- Rounding, shift=1: nout=5 → 3; nout=-5 → -2; nout=4 → 2. 16-bit mode plus flush after 3 results → word 0x0000_0002_FFFE_0003, m_lanes=3.
- Saturation, 8-bit shift 0: nout=300 → 0x7F; nout=-1000 → 0x80; sat_flag=1. clr_flags → 0.
- Reset with st=1 held, then en=1: the first st is ignored. The next st with en and armed captures. rst asserted mid-word → busy=0, m_valid=0 next cycle.
- m_ready=0, FIFO_DEPTH=4: 5 full words produced → 4 held and the 5th dropped, ovf_flag=1. Then m_ready=1 drains exactly 4 words in order.
- cfg_shift changed from 2 to 7 while en=1 → results still use 2; after en=0 for one cycle and re-enable, 7 applies.
